// File: rtl/cpu_trace_emitter.sv
// Serializes one register- or memory-write trace record into an ASCII character stream,
// one character per accepted output beat, with a registered valid/ready output.
module cpu_trace_emitter #(
    parameter int PAD_SPACES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        kind,
    input  logic [15:0] time_bcd,
    input  logic [31:0] pc,
    input  logic [4:0]  grf,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic [7:0]  char_out,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        err
);

    typedef enum logic [3:0] {
        S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON,
        S_PAD, S_TAG, S_FIELD, S_ARROW, S_DATA, S_HASH
    } state_t;

    localparam logic [3:0] PAD_LAST = 4'(PAD_SPACES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  char_q, char_d;
    logic        valid_q, err_q, err_d;

    logic        kind_q;
    logic [15:0] time_q;
    logic [31:0] pc_q, addr_q, data_q;
    logic [4:0]  grf_q;

    logic        consume, bcd_bad, grf_two;
    logic [1:0]  t_start, tdig_q, tdig_d, grf_tens;
    logic [4:0]  grf_sub;
    logic [3:0]  grf_ones;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
    endfunction

    function automatic logic [3:0] nib(input logic [31:0] w, input logic [2:0] i);
        return w[{3'd7 - i, 2'b00} +: 4];
    endfunction

    assign in_ready   = (state_q == S_IDLE);
    assign char_out   = char_q;
    assign char_valid = valid_q;
    assign err        = err_q;
    assign consume    = valid_q && char_ready;

    assign bcd_bad = (time_bcd[15:12] > 4'd9) || (time_bcd[11:8] > 4'd9) ||
                     (time_bcd[7:4]   > 4'd9) || (time_bcd[3:0]  > 4'd9);

    // First printed time digit: skips leading zero nibbles but always keeps the last one.
    assign t_start = (time_q[15:12] != 4'd0) ? 2'd0 :
                     (time_q[11:8]  != 4'd0) ? 2'd1 :
                     (time_q[7:4]   != 4'd0) ? 2'd2 : 2'd3;
    assign tdig_q  = t_start + cnt_q[1:0];
    assign tdig_d  = t_start + cnt_d[1:0];

    // Tens digit of grf from comparators; ones digit by subtracting a constant.
    assign grf_tens = (grf_q >= 5'd30) ? 2'd3 : (grf_q >= 5'd20) ? 2'd2 :
                      (grf_q >= 5'd10) ? 2'd1 : 2'd0;
    assign grf_two  = (grf_tens != 2'd0);
    always_comb begin
        case (grf_tens)
            2'd1:    grf_sub = 5'd10;
            2'd2:    grf_sub = 5'd20;
            2'd3:    grf_sub = 5'd30;
            default: grf_sub = 5'd0;
        endcase
    end
    assign grf_ones = 4'(grf_q - grf_sub);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        char_d  = 8'h00;
        if (state_q == S_IDLE) begin
            if (in_valid) begin
                if (bcd_bad) begin
                    err_d = 1'b1;
                end else begin
                    state_d = S_CARET;
                    cnt_d   = 4'd0;
                end
            end
        end else if (consume) begin
            cnt_d = cnt_q + 4'd1;
            case (state_q)
                S_CARET: begin state_d = S_TIME; cnt_d = 4'd0; end
                S_TIME:  if (tdig_q == 2'd3)    begin state_d = S_AT;    cnt_d = 4'd0; end
                S_AT:    begin state_d = S_PC; cnt_d = 4'd0; end
                S_PC:    if (cnt_q == 4'd7)     begin state_d = S_COLON; cnt_d = 4'd0; end
                S_COLON: begin state_d = S_PAD; cnt_d = 4'd0; end
                S_PAD:   if (cnt_q == PAD_LAST) begin state_d = S_TAG;   cnt_d = 4'd0; end
                S_TAG:   begin state_d = S_FIELD; cnt_d = 4'd0; end
                S_FIELD: if (kind_q ? (cnt_q == 4'd7) : (cnt_q == {3'd0, grf_two})) begin
                             state_d = S_ARROW; cnt_d = 4'd0;
                         end
                S_ARROW: if (cnt_q == 4'd3)     begin state_d = S_DATA;  cnt_d = 4'd0; end
                S_DATA:  if (cnt_q == 4'd7)     begin state_d = S_HASH;  cnt_d = 4'd0; end
                default: begin state_d = S_IDLE; cnt_d = 4'd0; end
            endcase
        end

        // The output register is loaded with the character for the upcoming position.
        case (state_d)
            S_CARET: char_d = 8'h5e;
            S_TIME:  char_d = hex_char(time_q[{2'd3 - tdig_d, 2'b00} +: 4]);
            S_AT:    char_d = 8'h40;
            S_PC:    char_d = hex_char(nib(pc_q, cnt_d[2:0]));
            S_COLON: char_d = 8'h3a;
            S_PAD:   char_d = 8'h20;
            S_TAG:   char_d = kind_q ? 8'h2a : 8'h24;
            S_FIELD: begin
                if (kind_q)
                    char_d = hex_char(nib(addr_q, cnt_d[2:0]));
                else if (grf_two && cnt_d == 4'd0)
                    char_d = hex_char({2'b00, grf_tens});
                else
                    char_d = hex_char(grf_ones);
            end
            S_ARROW: begin
                case (cnt_d[1:0])
                    2'd1:    char_d = 8'h3c;
                    2'd2:    char_d = 8'h3d;
                    default: char_d = 8'h20;
                endcase
            end
            S_DATA:  char_d = hex_char(nib(data_q, cnt_d[2:0]));
            S_HASH:  char_d = 8'h23;
            default: char_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            char_q  <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            char_q  <= char_d;
            valid_q <= (state_d != S_IDLE);
            err_q   <= err_d;
        end
    end

    // NOTE: the record fields are only read after a capture, so they carry no reset.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            kind_q <= kind;
            time_q <= time_bcd;
            pc_q   <= pc;
            grf_q  <= grf;
            addr_q <= addr;
            data_q <= data;
        end
    end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Scoreboard bench for cpu_trace_emitter: stimulus pushes hand-written expected records,
// a negedge monitor pops and compares every consumed character.
module tb_cpu_trace_emitter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        kind;
    logic [15:0] time_bcd;
    logic [31:0] pc;
    logic [4:0]  grf;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  char_out;
    logic        char_valid;
    logic        char_ready;
    logic        err;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    cpu_trace_emitter #(.PAD_SPACES(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .kind(kind), .time_bcd(time_bcd), .pc(pc), .grf(grf), .addr(addr),
        .data(data), .char_out(char_out), .char_valid(char_valid),
        .char_ready(char_ready), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares consumed characters and holds stalled characters steady.
    initial begin
        logic       stall_prev;
        logic [7:0] prev_char;
        stall_prev = 1'b0;
        prev_char  = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    check("stall_hold", {char_valid, char_out}, {1'b1, prev_char});
                if (char_valid && char_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_char: got=%0h expected=none at %0t", char_out, $time);
                    end else begin
                        check("char", char_out, exp_q.pop_front());
                    end
                end
                stall_prev = char_valid && !char_ready;
                prev_char  = char_out;
            end
        end
    end

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic drive(input logic k, input logic [15:0] t, input logic [31:0] p,
                         input logic [4:0] g, input logic [31:0] a, input logic [31:0] d);
        kind = k; time_bcd = t; pc = p; grf = g; addr = a; data = d;
        in_valid = 1'b1;
    endtask

    task automatic send(input logic k, input logic [15:0] t, input logic [31:0] p,
                        input logic [4:0] g, input logic [31:0] a, input logic [31:0] d,
                        input string s, input bit rnd, input bit hold);
        bit done;
        push_str(s);
        check("in_ready_before", in_ready, 1);
        drive(k, t, p, g, a, d);
        @(posedge clk); #1;
        check("first_char", {char_valid, char_out}, {1'b1, 8'h5e});
        // Scramble inputs: a captured record must ignore them.
        if (!hold) in_valid = 1'b0;
        kind = ~k; time_bcd = 16'h4321; pc = ~p; grf = ~g; addr = ~a; data = ~d;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (rnd) char_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (exp_q.size() == 0 && in_ready) done = 1'b1;
        end
        in_valid   = 1'b0;
        char_ready = 1'b1;
        check("record_done", done, 1);
        check("idle_valid", char_valid, 0);
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; char_ready = 1'b1;
        kind = 1'b0; time_bcd = 16'h0; pc = 32'h0; grf = 5'd0; addr = 32'h0; data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_char_valid", char_valid, 0);
        check("rst_char_out", char_out, 8'h00);
        check("rst_err", err, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        send(1'b0, 16'h0012, 32'h00003000, 5'd31, 32'h0, 32'hdeadbeef,
             "^12@00003000: $31 <= deadbeef#", 1'b0, 1'b0);
        send(1'b1, 16'h0000, 32'h0000300c, 5'd17, 32'h0000007c, 32'h0000abcd,
             "^0@0000300c: *0000007c <= 0000abcd#", 1'b0, 1'b1);
        send(1'b0, 16'h9999, 32'h00400000, 5'd0, 32'h0, 32'h00000000,
             "^9999@00400000: $0 <= 00000000#", 1'b0, 1'b0);
        send(1'b0, 16'h1000, 32'habcdef12, 5'd9, 32'h0, 32'h12345678,
             "^1000@abcdef12: $9 <= 12345678#", 1'b0, 1'b0);
        send(1'b0, 16'h0105, 32'h00000000, 5'd10, 32'h0, 32'hffffffff,
             "^105@00000000: $10 <= ffffffff#", 1'b0, 1'b0);
        send(1'b0, 16'h0007, 32'h00000001, 5'd29, 32'h0, 32'h00000010,
             "^7@00000001: $29 <= 00000010#", 1'b0, 1'b0);
        send(1'b0, 16'h0050, 32'hfedcba98, 5'd20, 32'h0, 32'ha5a5a5a5,
             "^50@fedcba98: $20 <= a5a5a5a5#", 1'b0, 1'b0);
        send(1'b0, 16'h0012, 32'h00003000, 5'd31, 32'h0, 32'hdeadbeef,
             "^12@00003000: $31 <= deadbeef#", 1'b1, 1'b0);

        // Invalid BCD: accepted, err pulse, nothing emitted.
        drive(1'b0, 16'h00a1, 32'h1, 5'd1, 32'h0, 32'h1);
        check("bad_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bad_err", err, 1);
        check("bad_valid", char_valid, 0);
        check("bad_idle", in_ready, 1);
        @(posedge clk); #1;
        check("bad_err_pulse", err, 0);
        check("bad_valid2", char_valid, 0);
        send(1'b1, 16'h0001, 32'h00000004, 5'd0, 32'h00000008, 32'h0000000c,
             "^1@00000004: *00000008 <= 0000000c#", 1'b0, 1'b0);

        // Reset in the middle of the PC field.
        push_str("^12@00003000: $31 <= deadbeef#");
        drive(1'b0, 16'h0012, 32'h00003000, 5'd31, 32'h0, 32'hdeadbeef);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_pc_char", {char_valid, char_out}, {1'b1, 8'h30});
        char_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        check("mid_rst_valid", char_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        reset = 1'b0;
        char_ready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_valid", char_valid, 0);
        send(1'b1, 16'h0034, 32'h00003010, 5'd3, 32'h00000100, 32'hcafef00d,
             "^34@00003010: *00000100 <= cafef00d#", 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
